// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: valid/ready command and response channels bridged onto a
// single-outstanding APB4 master port. Every output is driven from a register.
// Optional build macro: APB4_MASTER_TIMEOUT_EN -- aborts a transfer after
// TIMEOUT_CYCLES ACCESS cycles without M_PREADY (rsp_err=1, rsp_timeout=1).
// Without the macro there is no counter, ACCESS waits forever and rsp_timeout is 0.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  S_PCLK,
    input  logic                  S_PRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] M_PADDR,
    output logic                  M_PSEL,
    output logic                  M_PENABLE,
    output logic                  M_PWRITE,
    output logic [DATA_WIDTH-1:0] M_PWDATA,
    input  logic                  M_PREADY,
    input  logic [DATA_WIDTH-1:0] M_PRDATA,
    input  logic                  M_PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_cmd_ready,  w_cmd_ready_nxt;
    logic                    r_rsp_valid,  w_rsp_valid_nxt;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata,  w_rsp_rdata_nxt;
    logic                    r_rsp_err,    w_rsp_err_nxt;
    logic [ADDR_WIDTH-1:0]   r_paddr,      w_paddr_nxt;
    logic                    r_psel,       w_psel_nxt;
    logic                    r_penable,    w_penable_nxt;
    logic                    r_pwrite,     w_pwrite_nxt;
    logic [DATA_WIDTH-1:0]   r_pwdata,     w_pwdata_nxt;

    logic                    w_cmd_fire;
    logic                    w_tmo_hit;
    logic                    w_acc_done;

    assign w_cmd_fire = cmd_valid & r_cmd_ready;
    assign w_acc_done = (r_state == ST_ACCESS) && (w_state_nxt == ST_RESP);

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_tmo_cnt;
    logic       r_rsp_timeout;

    // Count ACCESS cycles without PREADY; restarted by every SETUP phase
    always_ff @(posedge S_PCLK or negedge S_PRESETN) begin
        if (!S_PRESETN) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !M_PREADY && !w_tmo_hit) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end
    end

    // PREADY in the threshold cycle takes priority over the abort
    assign w_tmo_hit = (r_state == ST_ACCESS) && !M_PREADY && (r_tmo_cnt == TMO_LAST);

    // Timeout flag captured alongside the other response fields
    always_ff @(posedge S_PCLK or negedge S_PRESETN) begin
        if (!S_PRESETN) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_acc_done) begin
            r_rsp_timeout <= w_tmo_hit;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_tmo_hit   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge S_PCLK or negedge S_PRESETN) begin
        if (!S_PRESETN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one outstanding transfer, cmd_valid only seen in IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_cmd_fire)             w_state_nxt = ST_SETUP;
            ST_SETUP:                              w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (M_PREADY || w_tmo_hit)  w_state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready)              w_state_nxt = ST_IDLE;
            default:                               w_state_nxt = ST_IDLE;
        endcase
    end

    // Output next-values, decoded from the state being entered so that the
    // registered outputs line up with the state they belong to
    always_comb begin
        w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
        w_psel_nxt      = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
        w_penable_nxt   = (w_state_nxt == ST_ACCESS);
        w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
        w_paddr_nxt     = r_paddr;
        w_pwrite_nxt    = r_pwrite;
        w_pwdata_nxt    = w_psel_nxt ? r_pwdata : '0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        if ((r_state == ST_IDLE) && (w_state_nxt == ST_SETUP)) begin
            w_paddr_nxt  = cmd_addr;
            w_pwrite_nxt = cmd_write;
            w_pwdata_nxt = cmd_write ? cmd_wdata : '0;
        end

        if (w_acc_done) begin
            if (M_PREADY) begin
                w_rsp_rdata_nxt = r_pwrite ? '0 : M_PRDATA;
                w_rsp_err_nxt   = M_PSLVERR;
            end else begin
                w_rsp_rdata_nxt = '0;
                w_rsp_err_nxt   = 1'b1;
            end
        end
    end

    // Output registers, all cleared asynchronously by reset
    always_ff @(posedge S_PCLK or negedge S_PRESETN) begin
        if (!S_PRESETN) begin
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_paddr     <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
        end else begin
            r_cmd_ready <= w_cmd_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_paddr     <= w_paddr_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_pwrite    <= w_pwrite_nxt;
            r_pwdata    <= w_pwdata_nxt;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign M_PADDR   = r_paddr;
    assign M_PSEL    = r_psel;
    assign M_PENABLE = r_penable;
    assign M_PWRITE  = r_pwrite;
    assign M_PWDATA  = r_pwdata;

endmodule
